// File: rtl/rx_frontend_cfg_pkg.sv
// Shared state encoding, shadow indices and replay order for the RX frontend
// configuration sequencer.
package rx_frontend_cfg_pkg;

  localparam int NUM_REGS = 6;

  localparam logic [2:0] IDX_MAG      = 3'd0;
  localparam logic [2:0] IDX_PHASE    = 3'd1;
  localparam logic [2:0] IDX_OFFSET_I = 3'd2;
  localparam logic [2:0] IDX_OFFSET_Q = 3'd3;
  localparam logic [2:0] IDX_IQ_MAP   = 3'd4;
  localparam logic [2:0] IDX_HET      = 3'd5;

  // IQ mapping goes first so the corrections that follow land on the final lane order.
  localparam logic [2:0] REPLAY_ORDER [NUM_REGS] = '{
    IDX_IQ_MAP, IDX_MAG, IDX_PHASE, IDX_OFFSET_I, IDX_OFFSET_Q, IDX_HET
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SYNC,
    S_WRITE,
    S_GAP,
    S_FLUSH,
    S_DONE
  } state_t;

endpackage

// File: rtl/rx_frontend_cfg_pick.sv
// Combinational priority pick: first dirty shadow index in replay order, plus
// a flag telling whether any register is still dirty.
module rx_frontend_cfg_pick
  import rx_frontend_cfg_pkg::*;
(
  input  logic [NUM_REGS-1:0] dirty,
  output logic [2:0]          idx,
  output logic                any
);

  // Walk the order backwards so the earliest dirty entry is the last one assigned.
  always_comb begin
    idx = IDX_MAG;
    any = 1'b0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (dirty[REPLAY_ORDER[i]]) begin
        idx = REPLAY_ORDER[i];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rx_frontend_cfg_seq.sv
// RX frontend configuration sequencer: shadows six settings registers, replays
// only the dirty ones on commit (one write per two cycles) and masks RX while settling.
module rx_frontend_cfg_seq
  import rx_frontend_cfg_pkg::*;
#(
  parameter logic [7:0] SR_MAG_CORRECTION   = 8'd0,
  parameter logic [7:0] SR_PHASE_CORRECTION = 8'd1,
  parameter logic [7:0] SR_OFFSET_I         = 8'd2,
  parameter logic [7:0] SR_OFFSET_Q         = 8'd3,
  parameter logic [7:0] SR_IQ_MAPPING       = 8'd4,
  parameter logic [7:0] SR_HET_PHASE_INCR   = 8'd5,
  parameter int         FLUSH_CYCLES        = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cfg_wr,
  input  logic [2:0]  cfg_idx,
  input  logic [31:0] cfg_data,
  input  logic        cfg_commit,
  input  logic        cfg_commit_sync,
  input  logic        sync_in,
  output logic        set_stb,
  output logic [7:0]  set_addr,
  output logic [31:0] set_data,
  output logic        busy,
  output logic        done,
  output logic        cfg_err,
  output logic        rx_mask
);

  localparam logic [7:0] FLUSH_LOAD = 8'(FLUSH_CYCLES - 1);

  state_t                        state;
  logic [NUM_REGS-1:0][31:0]     shadow;
  logic [NUM_REGS-1:0]           dirty;
  logic [NUM_REGS-1:0]           wr_mask;
  logic [NUM_REGS-1:0]           dirty_eff;
  logic [NUM_REGS-1:0]           pick_onehot;
  logic [7:0]                    flush_cnt;
  logic [2:0]                    pick_idx;
  logic                          pick_any;
  logic [31:0]                   pick_data;
  logic                          wr_ok;
  logic                          rejected;
  logic                          go_write;

  function automatic logic [7:0] sr_addr(input logic [2:0] idx);
    case (idx)
      IDX_MAG:      return SR_MAG_CORRECTION;
      IDX_PHASE:    return SR_PHASE_CORRECTION;
      IDX_OFFSET_I: return SR_OFFSET_I;
      IDX_OFFSET_Q: return SR_OFFSET_Q;
      IDX_IQ_MAP:   return SR_IQ_MAPPING;
      default:      return SR_HET_PHASE_INCR;
    endcase
  endfunction

  assign wr_ok    = (state == S_IDLE) && cfg_wr && (cfg_idx < 3'(NUM_REGS));
  assign rejected = (state != S_IDLE) ? (cfg_wr | cfg_commit) : (cfg_wr & ~wr_ok);

  // A write in the commit cycle must be visible to the very first pick.
  always_comb begin
    wr_mask = '0;
    if (wr_ok) wr_mask[cfg_idx] = 1'b1;
  end
  assign dirty_eff = dirty | wr_mask;

  rx_frontend_cfg_pick u_pick (
    .dirty (dirty_eff),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    pick_onehot           = '0;
    pick_onehot[pick_idx] = 1'b1;
  end

  assign pick_data = (wr_ok && cfg_idx == pick_idx) ? cfg_data : shadow[pick_idx];

  assign go_write = pick_any &&
                    ((state == S_IDLE && cfg_commit && !cfg_commit_sync) ||
                     (state == S_WAIT_SYNC && sync_in) ||
                     (state == S_GAP));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      shadow    <= '0;
      dirty     <= '1;
      flush_cnt <= '0;
      set_stb   <= 1'b0;
      set_addr  <= '0;
      set_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      rx_mask   <= 1'b0;
    end else begin
      set_stb <= 1'b0;
      done    <= 1'b0;
      cfg_err <= rejected;
      if (wr_ok) shadow[cfg_idx] <= cfg_data;

      case (state)
        S_IDLE: begin
          dirty <= dirty_eff;
          if (cfg_commit && !pick_any) begin
            state <= S_DONE;
            busy  <= 1'b1;
            done  <= 1'b1;
          end else if (cfg_commit && cfg_commit_sync) begin
            state <= S_WAIT_SYNC;
            busy  <= 1'b1;
          end
        end
        S_WAIT_SYNC: begin
        end
        // The final write skips GAP so the settle window starts right after it.
        S_WRITE: begin
          if (pick_any) begin
            state <= S_GAP;
          end else begin
            state     <= S_FLUSH;
            flush_cnt <= FLUSH_LOAD;
          end
        end
        S_GAP: begin
          if (!pick_any) begin
            state     <= S_FLUSH;
            flush_cnt <= FLUSH_LOAD;
          end
        end
        S_FLUSH: begin
          if (flush_cnt == 8'd0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt - 8'd1;
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          busy    <= 1'b0;
          rx_mask <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase

      if (go_write) begin
        state    <= S_WRITE;
        busy     <= 1'b1;
        rx_mask  <= 1'b1;
        set_stb  <= 1'b1;
        set_addr <= sr_addr(pick_idx);
        set_data <= pick_data;
        dirty    <= dirty_eff & ~pick_onehot;
      end
    end
  end

endmodule

// File: tb/tb_rx_frontend_cfg_seq.sv
// Scoreboard bench for rx_frontend_cfg_seq: stimulus predicts bus writes, done and
// error pulses from the register-replay rules; a negedge monitor pops and compares.
module tb_rx_frontend_cfg_seq;

  localparam int F = 32;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [2:0]  cfg_idx = '0;
  logic [31:0] cfg_data = '0;
  logic        cfg_commit = 1'b0;
  logic        cfg_commit_sync = 1'b0;
  logic        sync_in = 1'b0;
  logic        set_stb, busy, done, cfg_err, rx_mask;
  logic [7:0]  set_addr;
  logic [31:0] set_data;

  rx_frontend_cfg_seq #(.FLUSH_CYCLES(F)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cfg_wr          (cfg_wr),
    .cfg_idx         (cfg_idx),
    .cfg_data        (cfg_data),
    .cfg_commit      (cfg_commit),
    .cfg_commit_sync (cfg_commit_sync),
    .sync_in         (sync_in),
    .set_stb         (set_stb),
    .set_addr        (set_addr),
    .set_data        (set_data),
    .busy            (busy),
    .done            (done),
    .cfg_err         (cfg_err),
    .rx_mask         (rx_mask)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_ev_t;

  wr_ev_t      exp_wr_q[$];
  int          exp_done_q[$];
  int          exp_err_q[$];
  logic [31:0] m_shadow [6];
  bit          m_dirty [6];
  int          order [6] = '{4, 0, 1, 2, 3, 5};
  int          busy_lo = 0, busy_hi = -1, mask_lo = 0, mask_hi = -1;
  int          sync_at = -1, sync_noise = -1;
  int          n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  always @(negedge clk) begin
    wr_ev_t e;
    int     t;
    if (set_stb) begin
      if (exp_wr_q.size() == 0) chk("set_stb_unexpected", set_stb, 1'b0);
      else begin
        e = exp_wr_q.pop_front();
        chk("set_stb_cycle", cyc, e.cyc);
        chk("set_addr", set_addr, e.addr);
        chk("set_data", set_data, e.data);
      end
    end
    if (done) begin
      if (exp_done_q.size() == 0) chk("done_unexpected", done, 1'b0);
      else begin
        t = exp_done_q.pop_front();
        chk("done_cycle", cyc, t);
      end
    end
    if (cfg_err) begin
      if (exp_err_q.size() == 0) chk("cfg_err_unexpected", cfg_err, 1'b0);
      else begin
        t = exp_err_q.pop_front();
        chk("cfg_err_cycle", cyc, t);
      end
    end
    chk("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
    chk("rx_mask", rx_mask, (cyc >= mask_lo && cyc <= mask_hi));
  end

  initial forever begin
    @(posedge clk);
    #2;
    sync_in = (cyc == sync_at) || (cyc == sync_noise);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    exp_wr_q.delete();
    exp_done_q.delete();
    exp_err_q.delete();
    foreach (m_shadow[i]) begin
      m_shadow[i] = '0;
      m_dirty[i]  = 1'b1;
    end
    busy_lo = 0; busy_hi = -1; mask_lo = 0; mask_hi = -1;
    sync_at = -1; sync_noise = -1;
  endtask

  task automatic model_commit(input int c, input bit sy, input int sdel, input bit noise);
    int     n = 0;
    int     t0;
    wr_ev_t e;
    if (sy && noise) sync_noise = c;
    t0 = sy ? c + sdel + 1 : c + 1;
    foreach (order[k]) begin
      if (m_dirty[order[k]]) begin
        e.cyc  = t0 + 2 * n;
        e.addr = 8'(order[k]);
        e.data = m_shadow[order[k]];
        exp_wr_q.push_back(e);
        m_dirty[order[k]] = 1'b0;
        n++;
      end
    end
    busy_lo = c + 1;
    if (n == 0) begin
      busy_hi = c + 1;
      exp_done_q.push_back(c + 1);
    end else begin
      if (sy) sync_at = c + sdel;
      busy_hi = t0 + 2 * n - 1 + F;
      exp_done_q.push_back(busy_hi);
      mask_lo = t0;
      mask_hi = busy_hi;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  // One stimulus cycle; the model decides acceptance from its own busy window.
  task automatic step(input bit wr, input int idx, input logic [31:0] d,
                      input bit cm, input bit sy, input int sdel, input bit noise);
    int c = cyc;
    cfg_wr = wr; cfg_idx = 3'(idx); cfg_data = d;
    cfg_commit = cm; cfg_commit_sync = sy;
    if (c >= busy_lo && c <= busy_hi) begin
      if (wr || cm) exp_err_q.push_back(c + 1);
    end else begin
      if (wr) begin
        if (idx < 6) begin
          m_shadow[idx] = d;
          m_dirty[idx]  = 1'b1;
        end else begin
          exp_err_q.push_back(c + 1);
        end
      end
      if (cm) model_commit(c, sy, sdel, noise);
    end
    tick();
    cfg_wr = 1'b0; cfg_commit = 1'b0; cfg_commit_sync = 1'b0;
  endtask

  task automatic commit_round(input bit wr, input int idx, input logic [31:0] d,
                              input bit sy, input int sdel, input bit noise, input int nrej);
    int r;
    step(wr, idx, d, 1'b1, sy, sdel, noise);
    for (int j = 0; j < nrej; j++) begin
      if (cyc <= busy_hi) begin
        r = $urandom_range(busy_hi, cyc);
        wait_until(r);
        if ($urandom_range(0, 1) == 0) step(1'b1, $urandom_range(0, 5), $urandom, 1'b0, 1'b0, 0, 1'b0);
        else step(1'b0, 0, 32'd0, 1'b1, 1'($urandom_range(0, 1)), 1, 1'b0);
      end
    end
    wait_until(busy_hi + 1);
  endtask

  initial begin
    int c;
    int e3;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_set_stb", set_stb, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    chk("rst_rx_mask", rx_mask, 1'b0);
    chk("rst_set_addr", set_addr, 8'd0);
    chk("rst_set_data", set_data, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Full replay of reset defaults, then a two-register replay.
    commit_round(1'b0, 0, 32'd0, 1'b0, 0, 1'b0, 0);
    step(1'b1, 5, 32'h1, 1'b0, 1'b0, 0, 1'b0);
    step(1'b1, 2, 32'hC000_0000, 1'b0, 1'b0, 0, 1'b0);
    commit_round(1'b0, 0, 32'd0, 1'b0, 0, 1'b0, 0);

    // Synchronised commit, sync 20 cycles out, plus an ignored sync in the commit cycle.
    step(1'b1, 0, $urandom, 1'b0, 1'b0, 0, 1'b0);
    commit_round(1'b0, 0, 32'd0, 1'b1, 20, 1'b1, 0);

    // Write and commit rejected during FLUSH, then an empty commit.
    step(1'b1, 1, $urandom, 1'b0, 1'b0, 0, 1'b0);
    c = cyc;
    step(1'b0, 0, 32'd0, 1'b1, 1'b0, 0, 1'b0);
    wait_until(c + 5);
    step(1'b1, 3, 32'hDEAD_BEEF, 1'b0, 1'b0, 0, 1'b0);
    wait_until(c + 8);
    step(1'b0, 0, 32'd0, 1'b1, 1'b0, 0, 1'b0);
    wait_until(busy_hi + 1);
    commit_round(1'b0, 0, 32'd0, 1'b0, 0, 1'b0, 0);

    // Out-of-range index is rejected and leaves nothing to replay.
    step(1'b1, 6, 32'h1234_5678, 1'b0, 1'b0, 0, 1'b0);
    commit_round(1'b0, 0, 32'd0, 1'b0, 0, 1'b0, 0);

    for (int r = 0; r < 25; r++) begin
      int nw;
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) step(1'b1, $urandom_range(0, 7), $urandom, 1'b0, 1'b0, 0, 1'b0);
      commit_round(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom,
                   1'($urandom_range(0, 1)), $urandom_range(1, 12),
                   1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    // Reset while the third of several writes is on the bus.
    step(1'b1, 4, $urandom, 1'b0, 1'b0, 0, 1'b0);
    step(1'b1, 0, $urandom, 1'b0, 1'b0, 0, 1'b0);
    step(1'b1, 1, $urandom, 1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 0, 32'd0, 1'b1, 1'b0, 0, 1'b0);
    e3 = exp_wr_q[2].cyc;
    wait_until(e3);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk("set_stb_async_reset", set_stb, 1'b0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    chk("post_rst_set_addr", set_addr, 8'd0);
    chk("post_rst_set_data", set_data, 32'd0);
    commit_round(1'b0, 0, 32'd0, 1'b0, 0, 1'b0, 0);

    repeat (3) tick();
    chk("wr_q_left", exp_wr_q.size(), 0);
    chk("done_q_left", exp_done_q.size(), 0);
    chk("err_q_left", exp_err_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
